// File: rtl/masar_pkg.sv
// Shared definitions for the masar restoring divider: default widths, FSM encoding, counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package masar_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;

    // Wide enough to count steps for any dividend up to 255 bits.
    localparam int CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/masar_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module masar_div_step
    import masar_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW-1:0] rem_in,
    input  logic          dbit,
    input  logic [VW-1:0] dvs,
    output logic [VW-1:0] rem_out,
    output logic          qbit
);

    logic [VW:0] shifted;
    logic [VW:0] trial;
    logic        unused_trial_msb;

    // A kept difference is always below the divisor, except for a zero divisor where
    // only the low VW bits matter; either way the top bit of the trial is dropped.
    always_comb begin
        shifted          = {rem_in, dbit};
        trial            = shifted - {1'b0, dvs};
        qbit             = (shifted >= {1'b0, dvs});
        rem_out          = qbit ? trial[VW-1:0] : shifted[VW-1:0];
        unused_trial_msb = trial[VW];
    end

endmodule

// File: rtl/masar_div.sv
// Unsigned restoring divider, one quotient bit per cycle; optional zero-divisor shortcut under MASAR_DIV_ZERO_EN.
// Latency: out_valid DW+1 edges after accept counting the accept edge (1 for a zero divisor when MASAR_DIV_ZERO_EN).
// Backpressure: holds the result in DONE until out_ready; in_ready only in IDLE, no accept/deliver bypass.
module masar_div
    import masar_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
`ifdef MASAR_DIV_ZERO_EN
    output logic [VW-1:0] remainder,
    output logic          div_zero
`else
    output logic [VW-1:0] remainder
`endif
);

    state_t           state;
    logic [DW-1:0]    dvd_q;
    logic [DW-1:0]    quo_q;
    logic [VW-1:0]    dvs_q;
    logic [VW-1:0]    rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [VW-1:0]    step_rem;
    logic             step_qbit;

    masar_div_step #(
        .VW (VW)
    ) u_step (
        .rem_in  (rem_q),
        .dbit    (dvd_q[DW-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .qbit    (step_qbit)
    );

`ifdef MASAR_DIV_ZERO_EN
    logic dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            dz_q <= (divisor == '0);
        end
    end

    assign div_zero = dz_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dvd_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        cnt_q <= '0;
`ifdef MASAR_DIV_ZERO_EN
                        if (divisor == '0) begin
                            quo_q <= '1;
                            rem_q <= dividend[VW-1:0];
                            state <= ST_DONE;
                        end else begin
                            quo_q <= '0;
                            rem_q <= '0;
                            state <= ST_CALC;
                        end
`else
                        quo_q <= '0;
                        rem_q <= '0;
                        state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    dvd_q <= dvd_q << 1;
                    quo_q <= {quo_q[DW-2:0], step_qbit};
                    rem_q <= step_rem;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The edge that performs the last step also enters DONE.
                    if (cnt_q == CNT_W'(DW - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_IDLE) || (state == ST_CALC) || (state == ST_DONE));

    a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_CALC) |-> (cnt_q < CNT_W'(DW)));

    a_done_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(quotient) && $stable(remainder)));

endmodule

// File: tb/tb_masar_div.sv
// Scoreboard bench for masar_div: directed vectors, reset abort, stall, and random pairs with backpressure.
module tb_masar_div;

    localparam int DW = 16;
    localparam int VW = 8;
`ifdef MASAR_DIV_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 17;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
`ifdef MASAR_DIV_ZERO_EN
    logic          div_zero;
`endif

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        int          lat;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp_rand = 1'b0;
    bit   rdy_hold = 1'b1;

    masar_div #(
        .DW (DW),
        .VW (VW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
`ifdef MASAR_DIV_ZERO_EN
        .remainder (remainder),
        .div_zero  (div_zero)
`else
        .remainder (remainder)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
        end
    end

    // Monitor: latency from accept to out_valid (accept edge counted), then result on handshake.
    initial begin
        bit   ov_prev;
        exp_t e;
        int   lat;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc + 1);
                if (out_valid && !ov_prev) begin
                    if (acc_q.size() == 0 || exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected none", cyc);
                    end else begin
                        lat = cyc - acc_q.pop_front() + 1;
                        chk({exp_q[0].name, " latency"}, lat, exp_q[0].lat);
                    end
                end
                ov_prev = out_valid;
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({e.name, " quotient"}, quotient, e.q);
                    chk({e.name, " remainder"}, remainder, e.r);
`ifdef MASAR_DIV_ZERO_EN
                    chk({e.name, " div_zero"}, div_zero, (e.b == 0));
`endif
                    if (e.b != 0) begin
                        chk({e.name, " q*d+r"}, quotient * e.b + remainder, e.a);
                        chk({e.name, " r<d"}, remainder < e.b, 1);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                        input logic [7:0] r, input int lat, input bit expect_it,
                        input string nm, output int waited);
        exp_t e;
        bit   acc;
        if (expect_it) begin
            e.a = a; e.b = b; e.q = q; e.r = r; e.lat = lat; e.name = nm;
            exp_q.push_back(e);
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        acc      = 1'b0;
        waited   = 0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL %s accept: got no accept in %0d cycles, expected accept", nm, waited);
        end
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d results pending, expected 0", nm, exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " in_ready"}, in_ready, 1);
        chk({nm, " out_valid"}, out_valid, 0);
        chk({nm, " quotient"}, quotient, 0);
        chk({nm, " remainder"}, remainder, 0);
`ifdef MASAR_DIV_ZERO_EN
        chk({nm, " div_zero"}, div_zero, 0);
`endif
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        int          n;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] rq;
        logic [7:0]  rr;

        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'd3465, 8'd63, 16'd55, 8'd0, 17, 1'b1, "3465/63", w);
        chk("first accept edge", w, 1);
        wait_done("3465/63");
        send(16'd1000, 8'd7, 16'd142, 8'd6, 17, 1'b1, "1000/7", w);
        wait_done("1000/7");
        send(16'd65535, 8'd255, 16'd257, 8'd0, 17, 1'b1, "65535/255", w);
        wait_done("65535/255");

        rdy_hold = 1'b0;
        send(16'd66, 8'd3, 16'd22, 8'd0, 17, 1'b1, "66/3", w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall out_valid", out_valid, 1);
            chk("stall quotient", quotient, 22);
            chk("stall remainder", remainder, 0);
            chk("stall in_ready", in_ready, 0);
        end
        rdy_hold = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("release in_ready", in_ready, 1);
        chk("release out_valid", out_valid, 0);
        wait_done("66/3");

        send(16'd500, 8'd0, 16'hFFFF, 8'hF4, ZLAT, 1'b1, "500/0", w);
        wait_done("500/0");

        send(16'd65535, 8'd1, 16'd0, 8'd0, 0, 1'b0, "65535/1", w);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("post-abort out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(16'd1200, 8'd12, 16'd100, 8'd0, 17, 1'b1, "1200/12", w);
        wait_done("1200/12");

        bp_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 16'hFFFF;
            case ($urandom_range(0, 9))
                0:       rb = 8'd0;
                1:       rb = 8'd1;
                2:       rb = 8'd255;
                default: rb = 8'($urandom);
            endcase
            if (rb == 0) begin
                rq = 16'hFFFF;
                rr = ra[7:0];
            end else begin
                rq = ra / {8'd0, rb};
                rr = 8'(ra % {8'd0, rb});
            end
            send(ra, rb, rq, rr, (rb == 0) ? ZLAT : 17, 1'b1, "random", w);
            wait_done("random");
        end
        bp_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/masar_div.md
MASAR_DIV -- requirements
Module: masar_div

Interface
REQ-001 SHALL have parameter DW, default 16: dividend and quotient width in bits.
REQ-002 SHALL have parameter VW, default 8: divisor and remainder width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: dividend and divisor are offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts an operand pair.
REQ-007 SHALL have port dividend, input, DW: unsigned numerator.
REQ-008 SHALL have port divisor, input, VW: unsigned denominator.
REQ-009 SHALL have port out_valid, output, 1: quotient and remainder are valid.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-011 SHALL have port quotient, output, DW: unsigned quotient.
REQ-012 SHALL have port remainder, output, VW: unsigned remainder.
REQ-013 SHALL have port div_zero, output, 1, present only under MASAR_DIV_ZERO_EN: the divisor was zero.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready high only in IDLE.
REQ-016 SHALL drive out_valid high only in DONE.
REQ-017 SHALL, on an edge where in_valid and in_ready are both high, latch the operands, clear the partial remainder and the step counter, and enter CALC.
REQ-018 SHALL, in CALC, perform one restoring step per cycle, MSB first: shift left {partial remainder, next dividend bit}, trial-subtract the divisor at VW+1 bits, keep the difference and set the quotient bit if it is non-negative, otherwise restore.
REQ-019 SHALL leave CALC after exactly DW steps, so out_valid rises DW+1 edges after the accept edge (17 for the defaults).
REQ-020 SHALL hold quotient and remainder stable throughout DONE.
REQ-021 SHALL stay in DONE while out_ready is low; the result is never dropped.
REQ-022 SHALL, on an edge in DONE with out_ready high, return to IDLE; in_ready is not asserted in that same cycle, because there is no accept/deliver bypass.
REQ-023 SHALL ignore in_valid and operand changes while in CALC or DONE.
REQ-024 SHALL, for divisor 0, produce quotient = all ones and remainder = dividend[VW-1:0].
REQ-025 SHALL guarantee quotient*divisor+remainder = dividend and remainder < divisor for every non-zero divisor, over the full unsigned range of both operands.

Reset
REQ-026 SHALL, while rst_n is low, force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0 and div_zero=0, independent of clk.
REQ-027 SHALL abort any operation in progress when reset is asserted mid-CALC or mid-DONE; no result is emitted after release.
REQ-028 SHALL, after rst_n deasserts, first accept operands on the next rising edge with in_valid high.

Configuration
REQ-029 SHALL, with MASAR_DIV_ZERO_EN defined, present the div_zero port; a zero divisor goes from IDLE directly to DONE with out_valid rising 1 edge after accept, the values of REQ-024, and div_zero=1; div_zero is 0 for any non-zero divisor.
REQ-030 SHALL, with MASAR_DIV_ZERO_EN undefined, omit the div_zero port; a zero divisor runs the full DW-step latency and yields the values of REQ-024.

Structure
REQ-031 SHALL take DW/VW defaults, the state encoding type and the step-counter width from the shared package masar_pkg.
REQ-032 SHALL place the single restoring step in one combinational sub-module, masar_div_step: inputs partial remainder, dividend bit and divisor; outputs next remainder and quotient bit.

Verification
REQ-033 Bench SHALL apply 3465/63 -> quotient 55, remainder 0, out_valid 17 edges after accept.
REQ-034 Bench SHALL apply 1000/7 -> 142 r 6, and 65535/255 -> 257 r 0; each pair is sent only after the previous result has been taken.
REQ-035 Bench SHALL apply 66/3 with out_ready low for 5 cycles -> out_valid stays high, 22 r 0 stays stable, in_ready stays low, and IDLE is entered one edge after out_ready rises.
REQ-036 Bench SHALL apply 500/0 -> 0xFFFF r 0xF4; div_zero=1 with latency 1 when MASAR_DIV_ZERO_EN is defined, latency 17 when it is not.
REQ-037 Bench SHALL assert rst_n low at step 8 of 65535/1 -> immediate IDLE, all outputs 0, no out_valid after release; 1200/12 then gives 100 r 0.
REQ-038 Bench SHALL run 1000 random operand pairs with random backpressure and check REQ-025 on every result.
